// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between a read-only fetch port and a read/write data port.
// Round-robin grant, byte-to-word translation with range check, fixed-latency access, one-cycle acks.
module mem_port_arbiter #(
  parameter logic [31:0] MEM_BASE = 32'h0040_0000,
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic              grantData_q;
  logic              lastData_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              pickData;
  logic              selWe;
  logic              inRange;
  logic [31:0]       selAddr;
  logic [31:0]       selWdata;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] wordIdx;

  // On a tie the port that did not win the previous grant goes first.
  assign pickData = d_req & (~i_req | ~lastData_q);
  assign selAddr  = pickData ? d_addr : i_addr;
  assign selWe    = pickData & d_we;
  assign selWdata = pickData ? d_wdata : 32'd0;
  assign offset   = selAddr - MEM_BASE;
  assign wordIdx  = offset[ADDR_W+1:2];
  assign inRange  = (selAddr >= MEM_BASE) && ((offset >> (ADDR_W + 2)) == 32'd0);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grantData_q <= 1'b0;
      lastData_q  <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      i_ack       <= 1'b0;
      i_err       <= 1'b0;
      i_rdata     <= 32'd0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= 32'd0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
    end else begin
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            grantData_q <= pickData;
            lastData_q  <= pickData;
            we_q        <= selWe;
            if (inRange) begin
              state_q   <= ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= selWe;
              mem_addr  <= wordIdx;
              mem_wdata <= selWdata;
              cnt_q     <= CNT_W'(LATENCY - 1);
            end else begin
              // Out-of-range requests skip the memory and complete next cycle.
              state_q <= DONE;
              if (pickData) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= 32'd0;
              end else begin
                i_ack   <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= 32'd0;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (grantData_q) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= we_q ? 32'd0 : mem_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= 1'b0;
              i_rdata <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          LAT  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        iReq, iAck, iErr, dReq, dWe, dAck, dErr, memEn, memWe, busy;
  logic [31:0] iAddr, iRdata, dAddr, dWdata, dRdata, memWdata, memRdata;
  logic [9:0]  memAddr;

  logic        l3IReq, l3IAck, l3IErr, l3DAck, l3DErr, l3MemEn, l3MemWe, l3Busy;
  logic [31:0] l3IAddr, l3IRdata, l3DRdata, l3MemWdata;
  logic [9:0]  l3MemAddr;
  logic [31:0] l3MemRdata = 32'hCAFE_F00D;

  logic        memInit = 1'b0;
  logic [31:0] memArr [0:1023];
  logic [31:0] refMem [0:1023];

  function automatic logic [31:0] initWord(int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h0000_1357;
  endfunction

  // Behavioural memory macro: combinational read of the addressed word, write on the clock edge.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 1024; i++) memArr[i] <= initWord(i);
    end else if (memEn && memWe) begin
      memArr[memAddr] <= memWdata;
    end
  end
  assign memRdata = memArr[memAddr];

  mem_port_arbiter #(.MEM_BASE(BASE), .ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(iReq), .i_addr(iAddr), .i_ack(iAck), .i_err(iErr), .i_rdata(iRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_ack(dAck), .d_err(dErr), .d_rdata(dRdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_BASE(BASE), .ADDR_W(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req(l3IReq), .i_addr(l3IAddr), .i_ack(l3IAck), .i_err(l3IErr), .i_rdata(l3IRdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_ack(l3DAck), .d_err(l3DErr), .d_rdata(l3DRdata),
    .mem_en(l3MemEn), .mem_we(l3MemWe), .mem_addr(l3MemAddr), .mem_wdata(l3MemWdata),
    .mem_rdata(l3MemRdata), .busy(l3Busy)
  );

  function automatic logic [31:0] randAddr();
    int sel = int'($urandom_range(0, 9));
    if (sel < 7) return BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    if (sel == 7) return BASE + 32'($urandom_range(1016, 1023)) * 4;
    if (sel == 8) return BASE + 32'h1000 + 32'($urandom_range(0, 255)) * 4;
    return BASE - 32'd4 - 32'($urandom_range(0, 255)) * 4;
  endfunction

  task automatic applyReset;
    rst_n = 1'b0; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0; l3IReq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    iAddr = 32'd0; dAddr = 32'd0; dWdata = 32'd0; l3IReq = 1'b0; l3IAddr = 32'd0;
    @(negedge clk);
    checks++; if ({iAck, dAck, iErr, dErr, memEn, memWe, busy} !== 7'b0) begin errors++;
      $display("[TB] FAIL reset_flags got %b exp %b", {iAck, dAck, iErr, dErr, memEn, memWe, busy}, 7'b0); end
    checks++; if ({iRdata, dRdata, memWdata} !== 96'd0) begin errors++;
      $display("[TB] FAIL reset_data got %h exp 0", {iRdata, dRdata, memWdata}); end
    checks++; if (memAddr !== 10'd0) begin errors++;
      $display("[TB] FAIL reset_mem_addr got %h exp 0", memAddr); end
    checks++; if ({l3Busy, l3MemEn, l3IAck} !== 3'b0) begin errors++;
      $display("[TB] FAIL reset_lat3 got %b exp 000", {l3Busy, l3MemEn, l3IAck}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy, memEn} !== 2'b0) begin errors++;
      $display("[TB] FAIL reset_release_idle got %b exp 00", {busy, memEn}); end
  endtask

  task automatic test_data_write;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h0040_0FFC; dWdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if ({memEn, memWe, dAck} !== 3'b110) begin errors++;
      $display("[TB] FAIL write_strobe got %b exp 110", {memEn, memWe, dAck}); end
    checks++; if (memAddr !== 10'd1023) begin errors++;
      $display("[TB] FAIL write_mem_addr got %0d exp 1023", memAddr); end
    checks++; if (memWdata !== 32'h1234_5678) begin errors++;
      $display("[TB] FAIL write_mem_wdata got %h exp 12345678", memWdata); end
    @(negedge clk);
    checks++; if ({dAck, dErr, memEn, iAck} !== 4'b1000) begin errors++;
      $display("[TB] FAIL write_ack got %b exp 1000", {dAck, dErr, memEn, iAck}); end
    checks++; if (dRdata !== 32'd0) begin errors++;
      $display("[TB] FAIL write_rdata got %h exp 0", dRdata); end
    dReq = 1'b0; dWe = 1'b0;
    refMem[1023] = 32'h1234_5678;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("[TB] FAIL write_back_idle got %b exp 0", busy); end
  endtask

  task automatic test_fetch_read;
    dReq = 1'b1; dWe = 1'b1; dAddr = BASE + 32'd8; dWdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    checks++; if (dAck !== 1'b1) begin errors++;
      $display("[TB] FAIL preload_ack got %b exp 1", dAck); end
    dReq = 1'b0; dWe = 1'b0;
    refMem[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    iReq = 1'b1; iAddr = BASE + 32'd8;
    @(negedge clk);
    checks++; if ({memEn, memWe, memAddr} !== {2'b10, 10'd2}) begin errors++;
      $display("[TB] FAIL fetch_mem got en=%b we=%b addr=%0d exp en=1 we=0 addr=2", memEn, memWe, memAddr); end
    @(negedge clk);
    checks++; if ({iAck, iErr, dAck} !== 3'b100) begin errors++;
      $display("[TB] FAIL fetch_ack got %b exp 100", {iAck, iErr, dAck}); end
    checks++; if (iRdata !== 32'hDEAD_BEEF) begin errors++;
      $display("[TB] FAIL fetch_rdata got %h exp deadbeef", iRdata); end
    iReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie;
    int acks = 0;
    logic [3:0] order = 4'b0;
    applyReset();
    iReq = 1'b1; dReq = 1'b1; dWe = 1'b0; iAddr = BASE + 32'd20; dAddr = BASE + 32'd24;
    for (int k = 0; k < 30 && acks < 4; k++) begin
      @(negedge clk);
      checks++; if (iAck && dAck) begin errors++;
        $display("[TB] FAIL tie_both_acks got 1 exp 0"); end
      if (iAck) begin
        checks++; if (iRdata !== refMem[5]) begin errors++;
          $display("[TB] FAIL tie_fetch_rdata got %h exp %h", iRdata, refMem[5]); end
      end
      if (dAck) begin
        checks++; if (dRdata !== refMem[6]) begin errors++;
          $display("[TB] FAIL tie_data_rdata got %h exp %h", dRdata, refMem[6]); end
      end
      if (iAck || dAck) begin
        order[acks] = dAck;
        acks++;
      end
    end
    iReq = 1'b0; dReq = 1'b0;
    checks++; if (acks != 4) begin errors++;
      $display("[TB] FAIL tie_grant_count got %0d exp 4", acks); end
    checks++; if (order !== 4'b1010) begin errors++;
      $display("[TB] FAIL tie_order got %b exp 1010", order); end
    @(negedge clk);
  endtask

  task automatic test_range_errors;
    logic [31:0] addrs [3] = '{32'h0040_1000, 32'h003F_FFFC, 32'h1001_0000};
    bit          isData [3] = '{1'b1, 1'b1, 1'b0};
    bit          isWe [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      if (isData[k]) begin
        dReq = 1'b1; dWe = isWe[k]; dAddr = addrs[k]; dWdata = 32'hFFFF_0000;
      end else begin
        iReq = 1'b1; iAddr = addrs[k];
      end
      @(negedge clk);
      checks++; if ({isData[k] ? dAck : iAck, isData[k] ? dErr : iErr, memEn, busy} !== 4'b1101) begin errors++;
        $display("[TB] FAIL range_err_ack case %0d got ack,err,en,busy=%b exp 1101", k,
                 {isData[k] ? dAck : iAck, isData[k] ? dErr : iErr, memEn, busy}); end
      checks++; if ((isData[k] ? dRdata : iRdata) !== 32'd0) begin errors++;
        $display("[TB] FAIL range_err_rdata case %0d got %h exp 0", k, isData[k] ? dRdata : iRdata); end
      iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
      @(negedge clk);
      checks++; if ({isData[k] ? dAck : iAck, isData[k] ? dErr : iErr, busy} !== 3'b010) begin errors++;
        $display("[TB] FAIL range_err_hold case %0d got ack,err,busy=%b exp 010", k,
                 {isData[k] ? dAck : iAck, isData[k] ? dErr : iErr, busy}); end
    end
  endtask

  task automatic test_reset_abort;
    iReq = 1'b1; iAddr = BASE + 32'd8;
    @(posedge clk);
    #2;
    checks++; if ({memEn, busy} !== 2'b11) begin errors++;
      $display("[TB] FAIL abort_pre got en,busy=%b exp 11", {memEn, busy}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({memEn, busy, iAck} !== 3'b000) begin errors++;
      $display("[TB] FAIL abort_immediate got en,busy,ack=%b exp 000", {memEn, busy, iAck}); end
    @(negedge clk);
    checks++; if ({iAck, busy} !== 2'b00) begin errors++;
      $display("[TB] FAIL abort_no_ack got ack,busy=%b exp 00", {iAck, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({memEn, memAddr, iAck} !== {1'b1, 10'd2, 1'b0}) begin errors++;
      $display("[TB] FAIL abort_restart got en=%b addr=%0d ack=%b exp en=1 addr=2 ack=0", memEn, memAddr, iAck); end
    @(negedge clk);
    checks++; if ({iAck, iErr} !== 2'b10 || iRdata !== 32'hDEAD_BEEF) begin errors++;
      $display("[TB] FAIL abort_restart_ack got ack=%b err=%b rdata=%h exp ack=1 err=0 rdata=deadbeef", iAck, iErr, iRdata); end
    iReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency3;
    l3IReq = 1'b1; l3IAddr = BASE + 32'd16;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if ({l3MemEn, l3IAck, l3Busy} !== {k == 1, k == 4, k <= 4}) begin errors++;
        $display("[TB] FAIL lat3_timing cycle T+%0d got en,ack,busy=%b exp %b", k,
                 {l3MemEn, l3IAck, l3Busy}, {k == 1, k == 4, k <= 4}); end
      if (k <= 3) begin
        checks++; if (l3MemAddr !== 10'd4) begin errors++;
          $display("[TB] FAIL lat3_mem_addr cycle T+%0d got %0d exp 4", k, l3MemAddr); end
      end
      if (k == 4) begin
        checks++; if (l3IRdata !== 32'hCAFE_F00D || l3IErr !== 1'b0) begin errors++;
          $display("[TB] FAIL lat3_rdata got %h err %b exp cafef00d err 0", l3IRdata, l3IErr); end
      end
      // Dropping req mid-transaction must not cancel it.
      if (k == 2) l3IReq = 1'b0;
    end
  endtask

  // Transaction-level model: one transaction at a time, ack LAT+1 cycles after the grant
  // (1 cycle for out-of-range), next grant no earlier than the cycle after the ack.
  task automatic test_random(input int n);
    int          grantCyc = -10, ackCyc = -10;
    bit          pending = 1'b0, lastData = 1'b1;
    bit          gData = 1'b0, gErr = 1'b0, gWe = 1'b0, inR;
    logic [9:0]  gIdx = '0;
    logic [31:0] gWdata = '0, gRd = '0, addr;
    logic [31:0] expIRd = '0, expDRd = '0;
    bit          expIErr = 1'b0, expDErr = 1'b0, expIAck, expDAck, expEn, expBusy;
    applyReset();
    for (int c = 0; c < n; c++) begin
      expIAck = pending && c == ackCyc && !gData;
      expDAck = pending && c == ackCyc && gData;
      expEn   = pending && !gErr && c == grantCyc + 1;
      expBusy = pending && c > grantCyc;
      if (expIAck) begin expIRd = gRd; expIErr = gErr; end
      if (expDAck) begin expDRd = gRd; expDErr = gErr; end
      checks++; if ({iAck, dAck, memEn, busy} !== {expIAck, expDAck, expEn, expBusy}) begin errors++;
        $display("[TB] FAIL rand_ctrl cycle %0d got iack,dack,en,busy=%b exp %b", c,
                 {iAck, dAck, memEn, busy}, {expIAck, expDAck, expEn, expBusy}); end
      checks++; if ({iRdata, iErr, dRdata, dErr} !== {expIRd, expIErr, expDRd, expDErr}) begin errors++;
        $display("[TB] FAIL rand_resp cycle %0d got i=%h/%b d=%h/%b exp i=%h/%b d=%h/%b", c,
                 iRdata, iErr, dRdata, dErr, expIRd, expIErr, expDRd, expDErr); end
      if (expEn) begin
        checks++; if (memWe !== gWe || memAddr !== gIdx || (gWe && memWdata !== gWdata)) begin errors++;
          $display("[TB] FAIL rand_mem cycle %0d got we=%b addr=%0d wdata=%h exp we=%b addr=%0d wdata=%h", c,
                   memWe, memAddr, memWdata, gWe, gIdx, gWdata); end
      end
      if (pending && c == ackCyc) begin
        pending = 1'b0;
        if (gData) begin
          dReq = ($urandom_range(0, 2) == 0);
          dWe = 1'($urandom_range(0, 1)); dAddr = randAddr(); dWdata = $urandom();
        end else begin
          iReq = ($urandom_range(0, 2) == 0);
          iAddr = randAddr();
        end
      end else if (pending && c > grantCyc && $urandom_range(0, 7) == 0) begin
        if (gData) dReq = 1'b0; else iReq = 1'b0;
      end
      if (!iReq && !(pending && !gData) && $urandom_range(0, 2) == 0) begin
        iReq = 1'b1; iAddr = randAddr();
      end
      if (!dReq && !(pending && gData) && $urandom_range(0, 2) == 0) begin
        dReq = 1'b1; dWe = 1'($urandom_range(0, 1)); dAddr = randAddr(); dWdata = $urandom();
      end
      if (!pending && c > ackCyc && (iReq || dReq)) begin
        gData    = dReq && (!iReq || !lastData);
        lastData = gData;
        addr     = gData ? dAddr : iAddr;
        gWe      = gData && dWe;
        gWdata   = dWdata;
        inR      = (addr >= BASE) && (addr - BASE < 32'd4096);
        gErr     = !inR;
        gIdx     = 10'((addr - BASE) / 4);
        gRd      = 32'd0;
        if (inR && gWe) refMem[gIdx] = gWdata;
        else if (inR) gRd = refMem[gIdx];
        grantCyc = c;
        ackCyc   = c + (inR ? LAT + 1 : 1);
        pending  = 1'b1;
      end
      @(negedge clk);
    end
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0; iAddr = '0; dAddr = '0; dWdata = '0;
    l3IReq = 1'b0; l3IAddr = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
    memInit = 1'b1;
    @(negedge clk);
    memInit = 1'b0;
    test_reset();
    test_data_write();
    test_fetch_read();
    test_tie();
    test_range_errors();
    test_reset_abort();
    test_latency3();
    test_random(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
